// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_VALID,
    ST_HALT
  } state_t;

  // Top three bits of a halt instruction (only decoded when FETCH_HALT_EN is defined).
  localparam logic [2:0] HALT_OPCODE = 3'b111;

  // Width of the latency down-counter: must hold the value MEM_LAT.
  function automatic int lat_w(input int mem_lat);
    return (mem_lat < 1) ? 1 : $clog2(mem_lat + 1);
  endfunction

endpackage

// File: rtl/fetch_lat_timer.sv
// Loadable down-counter that flags the last cycle of a memory read.
// Latency: done is high in the cycle the count equals 1, i.e. load_val cycles after load.
// Backpressure: none; counts freely once loaded, stops at zero.
//
// Ports: clk, reset (sync, active-high), load / load_val (start a count),
//        done (high during the final counted cycle).
module fetch_lat_timer #(
  parameter int LAT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             done
);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  // After loading N, the count reads N..1 over the next N cycles; the
  // cycle reading 1 is the one in which read data is valid.
  assign done = (cnt == LAT_W'(1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads memory with MEM_LAT latency, presents ir via valid/ready.
// Latency: ISSUE in cycle t -> ir_valid from t+MEM_LAT+1; one instruction per MEM_LAT+2 cycles.
// Backpressure: ir/pc held while ir_valid & !ir_ready; no new fetch until the word is accepted.
//
// Ports: clk, reset (sync, active-high), run (fetch enable);
//        memory: mem_addr, mem_rd, mem_rdata; data port: data_req, data_addr, data_grant;
//        controller: ir, pc, ir_valid, ir_ready, redirect, redirect_pc, halted.
// Optional feature: define FETCH_HALT_EN to decode 3'b111-prefixed words as halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WORD_W   = 16,
  parameter int               ADDR_W   = 8,
  parameter int               MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              data_grant,
  output logic [WORD_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int LAT_W = lat_w(MEM_LAT);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic              timer_load;
  logic              timer_done;
  logic              capture;
  logic              accept;
  logic              is_halt;

  fetch_lat_timer #(
    .LAT_W (LAT_W)
  ) u_lat_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (LAT_W'(MEM_LAT)),
    .done     (timer_done)
  );

`ifdef FETCH_HALT_EN
  assign is_halt = (ir[WORD_W-1 -: 3] == HALT_OPCODE);
`else
  assign is_halt = 1'b0;
`endif

  // Next state and the combinational memory-port outputs. The data port
  // borrows mem_addr in every state except WAIT, where an instruction read
  // is in flight and the address must stay on fetch_pc.
  always_comb begin
    state_nxt  = state;
    mem_addr   = fetch_pc;
    mem_rd     = 1'b0;
    data_grant = 1'b0;
    timer_load = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (data_req) begin
          data_grant = 1'b1;
          mem_addr   = data_addr;
        end
        if (run) state_nxt = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (data_req) begin
          data_grant = 1'b1;
          mem_addr   = data_addr;
        end else if (run) begin
          mem_rd     = 1'b1;
          timer_load = 1'b1;
          state_nxt  = ST_WAIT;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (timer_done) begin
          capture   = 1'b1;
          state_nxt = ST_VALID;
        end
      end

      ST_VALID: begin
        if (data_req) begin
          data_grant = 1'b1;
          mem_addr   = data_addr;
        end
        if (ir_ready) begin
          accept = 1'b1;
          if (is_halt)  state_nxt = ST_HALT;
          else if (run) state_nxt = ST_ISSUE;
          else          state_nxt = ST_IDLE;
        end
      end

      ST_HALT: begin
        if (data_req) begin
          data_grant = 1'b1;
          mem_addr   = data_addr;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      ir       <= '0;
      pc       <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        ir       <= mem_rdata;
        pc       <= fetch_pc;
        ir_valid <= 1'b1;
      end
      if (accept) begin
        ir_valid <= 1'b0;
        // Sequential successor wraps naturally at 2^ADDR_W.
        fetch_pc <= redirect ? redirect_pc : pc + ADDR_W'(1);
      end
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (accept && is_halt) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch engine for the RISC core, replacing the fixed 8-bit program counter and instruction register. It owns the program counter, issues instruction reads to a memory with configurable read latency, and holds the fetched word in an instruction register behind a valid/ready handshake to the controller. It arbitrates the shared memory address between instruction fetch and controller data accesses, and supports branch redirect and an optional halt instruction.

## Interface
- WORD_W, 16, instruction/memory word width (≥ 8)
- ADDR_W, 8, memory address width
- MEM_LAT, 1, memory read latency in cycles (≥ 1)
- RESET_PC, 0, first fetch address after reset
---
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level enable; fetching starts/continues while high
- mem_addr  out  ADDR_W  shared memory address
- mem_rd  out  1  instruction read issue strobe
- mem_rdata  in  WORD_W  memory read data
- data_req  in  1  controller requests memory for a data access
- data_addr  in  ADDR_W  data access address
- data_grant  out  1  mem_addr currently drives data_addr
- ir  out  WORD_W  current instruction
- pc  out  ADDR_W  address the word in ir was fetched from
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_ready  in  1  controller accepts ir
- redirect  in  1  qualify next PC on accept
- redirect_pc  in  ADDR_W  branch target
- halted  out  1  halt instruction consumed

## Operation
- States: IDLE, ISSUE, WAIT, VALID, HALT.
- Reset: state IDLE, fetch_pc = RESET_PC, ir = 0, pc = 0, ir_valid = 0, mem_rd = 0, data_grant = 0, halted = 0. Reset in any state (including mid-WAIT) aborts the read; no capture occurs.
- IDLE: mem_addr = fetch_pc unless granted. run=1 → ISSUE.
- ISSUE: if data_req=1, data_grant=1, mem_addr=data_addr, mem_rd=0, stay ISSUE. Otherwise mem_rd=1, mem_addr=fetch_pc, latency timer loaded with MEM_LAT → WAIT.
- WAIT: mem_addr held at fetch_pc; data_req ignored (data_grant=0). Timer decrements each cycle; on last WAIT cycle mem_rdata captured into ir, pc ← fetch_pc → VALID.
- VALID: ir_valid=1. data_req granted (data_grant=1, mem_addr=data_addr) whenever asserted. On ir_valid & ir_ready: fetch_pc ← redirect ? redirect_pc : pc + 1 (mod 2^ADDR_W, wraps to 0); next state ISSUE if run else IDLE (or HALT, see Configuration). ir and pc hold until next capture.
- run deassert during ISSUE (without data_req) → IDLE; during WAIT the read completes and enters VALID.
- Data grant in IDLE and HALT follows data_req combinationally.

## Timing
- data_grant, mem_addr, mem_rd combinational from state and data_req; ir, pc, ir_valid, halted registered.
- ISSUE in cycle t; mem_rdata must be valid in cycle t+MEM_LAT; ir_valid high from t+MEM_LAT+1.
- Back-to-back throughput with ir_ready held high: one instruction per MEM_LAT+2 cycles.
- Accept cycle and ISSUE of next fetch are separate cycles; no fetch overlaps VALID.
- redirect/redirect_pc sampled only in the accept cycle; ignored otherwise.

## Configuration
- FETCH_HALT_EN defined: an instruction whose top three bits are 3'b111 is a halt; on its accept state → HALT, halted=1 from next cycle, no further fetch until reset; data_req still granted.
- Undefined: 3'b111 words are ordinary instructions, HALT state unreachable, halted tied 0.

## Structure
- Shared package fetch_pkg: state enum, HALT_OPCODE = 3'b111, LAT_W = $clog2(MEM_LAT+1) helper.
- One sub-module fetch_lat_timer: loadable down-counter with done flag, width LAT_W.

## Test plan
- Reset, run=1, MEM_LAT=1, memory[0]=16'hA123, ir_ready=1 → mem_rd in cycle 1, ir=16'hA123, pc=0, ir_valid at cycle 3; next fetch address 1.
- MEM_LAT=3, ir_ready low 5 cycles → ir_valid held, ir stable, no mem_rd until accept; next ISSUE the cycle after accept.
- Accept with redirect=1, redirect_pc=8'h40 → next mem_addr 8'h40, pc=8'h40 after capture; redirect asserted outside accept ignored.
- pc=8'hFF accepted, no redirect → next fetch address 8'h00.
- data_req=1, data_addr=8'h80 during ISSUE for 2 cycles → data_grant=1, mem_rd=0, then fetch resumes; data_req during WAIT → data_grant=0, mem_addr unchanged.
- FETCH_HALT_EN: fetch 16'hE000, accept → halted=1, no further mem_rd; reset mid-WAIT → IDLE, ir_valid=0, fetch restarts at RESET_PC.
